// File: rtl/gf2_prng_pkg.sv
// Shared types and default constants for the GF(2)[x] affine PRNG.
// Holds the sequencer FSM encoding and the 31-bit default polynomials.
package gf2_prng_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } fsm_t;

    localparam int unsigned DEF_N      = 31;
    localparam logic [30:0] DEF_A_POLY = 31'h00000011;
    localparam logic [30:0] DEF_C_POLY = 31'h00000001;
    localparam logic [30:0] DEF_H_LOW  = 31'h00002109;

endpackage

// File: rtl/gf2_poly_digit_step.sv
// One digit of a Horner multiply over GF(2)[x] mod h(x).
// Consumes DIGIT bits of a(x), MSB first: acc = acc*x mod h ^ (a_j ? state : 0).
module gf2_poly_digit_step #(
    parameter int         N     = 31,
    parameter int         DIGIT = 1,
    parameter logic [N-1:0] H_LOW = '0
) (
    input  logic [N-1:0]     acc,
    input  logic [N-1:0]     state,
    input  logic [DIGIT-1:0] digit,
    output logic [N-1:0]     acc_next
);

    logic [N-1:0] a;

    // Unrolled Horner steps for the bits of this digit
    always_comb begin
        a = acc;
        for (int j = DIGIT - 1; j >= 0; j--) begin
            a = {a[N-2:0], 1'b0}
              ^ (a[N-1] ? H_LOW : '0)
              ^ (digit[j] ? state : '0);
        end
        acc_next = a;
    end

endmodule

// File: rtl/gf2_poly_affine_prng_seq.sv
// Digit-serial affine PRNG: s(k+1) = a(x)*s(k) + c(x) mod h(x).
// Optional macro GF2_PRNG_SAMPLE_CNT_EN enables the accepted-sample counter.
module gf2_poly_affine_prng_seq
    import gf2_prng_pkg::*;
#(
    parameter int           N      = DEF_N,
    parameter logic [N-1:0] A_POLY = DEF_A_POLY,
    parameter logic [N-1:0] C_POLY = DEF_C_POLY,
    parameter logic [N-1:0] H_LOW  = DEF_H_LOW,
    parameter int           DIGIT  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_load,
    input  logic [N-1:0] seed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy,
    output logic [31:0]  sample_cnt
);

    localparam int L  = (N + DIGIT - 1) / DIGIT;
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    localparam int PW = L * DIGIT;

    // a(x) zero-padded on the MSB side to a whole number of digits
    localparam logic [PW-1:0] A_PAD = PW'(A_POLY);
    localparam logic [CW-1:0] LAST  = CW'(L - 1);

    fsm_t         fsm_q;
    logic [N-1:0] state_q;
    logic [N-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0] acc_next;
    logic [DIGIT-1:0] digit;
    logic [CW-1:0] digit_idx;
    logic [PW-1:0] a_shift;
    logic          hs;

    // Select the a(x) digit for this iteration, most significant first
    always_comb begin
        digit_idx = LAST - cnt_q;
        a_shift   = A_PAD >> (digit_idx * DIGIT);
        digit     = a_shift[DIGIT-1:0];
    end

    gf2_poly_digit_step #(
        .N     (N),
        .DIGIT (DIGIT),
        .H_LOW (H_LOW)
    ) u_step (
        .acc      (acc_q),
        .state    (state_q),
        .digit    (digit),
        .acc_next (acc_next)
    );

    assign hs   = (fsm_q == OUT) & out_valid & out_ready & ~seed_load;
    assign busy = (fsm_q == CALC);

    // Sequencer: seed load, iterative multiply, output hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (seed_load) begin
            fsm_q     <= CALC;
            state_q   <= seed;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    out_valid <= 1'b0;
                end
                CALC: begin
                    acc_q <= acc_next;
                    if (cnt_q == LAST) begin
                        out_data  <= acc_next ^ C_POLY;
                        out_valid <= 1'b1;
                        fsm_q     <= OUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q   <= out_data;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        out_valid <= 1'b0;
                        fsm_q     <= CALC;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

`ifdef GF2_PRNG_SAMPLE_CNT_EN
    // Count accepted samples since the last seed load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (seed_load) begin
            sample_cnt <= '0;
        end else if (hs) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end
`else
    assign sample_cnt = 32'd0;
    logic unused_hs;
    assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_gf2_poly_affine_prng_seq.sv
// Self-checking bench for gf2_poly_affine_prng_seq.
// Reference model: schoolbook GF(2) product then long-division reduction.
module tb_gf2_poly_affine_prng_seq;

    localparam logic [30:0] A_P = 31'h00000011;
    localparam logic [30:0] C_P = 31'h00000001;
    localparam logic [30:0] H_L = 31'h00002109;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [30:0] seed = '0;
    logic        rdy1 = 1'b0;
    logic        rdy4 = 1'b0;
    logic        rdy31 = 1'b0;

    logic        v1, v4, v31;
    logic [30:0] d1, d4, d31;
    logic        b1, b4, b31;
    logic [31:0] c1, c4, c31;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gf2_poly_affine_prng_seq #(.DIGIT(1)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .out_valid(v1), .out_ready(rdy1), .out_data(d1),
        .busy(b1), .sample_cnt(c1)
    );

    gf2_poly_affine_prng_seq #(.DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .out_valid(v4), .out_ready(rdy4), .out_data(d4),
        .busy(b4), .sample_cnt(c4)
    );

    gf2_poly_affine_prng_seq #(.DIGIT(31)) dut31 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .out_valid(v31), .out_ready(rdy31), .out_data(d31),
        .busy(b31), .sample_cnt(c31)
    );

    function automatic logic [30:0] next_elem(input logic [30:0] s);
        logic [61:0] p;
        logic [61:0] h;
        p = '0;
        for (int i = 0; i < 31; i++)
            if (A_P[i]) p = p ^ (62'(s) << i);
        h = {31'd0, 1'b1, H_L};
        for (int i = 61; i >= 31; i--)
            if (p[i]) p = p ^ (h << (i - 31));
        return p[30:0] ^ C_P;
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef GF2_PRNG_SAMPLE_CNT_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n & 0) ;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic load(input logic [30:0] v);
        @(negedge clk);
        seed_load = 1'b1;
        seed = v;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int cyc, output bit ok);
        cyc = 0;
        ok = 1'b0;
        while (cyc < max && !ok) begin
            @(posedge clk);
            #1;
            cyc++;
            if (v1) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got no out_valid expected within %0d", max);
        end
    endtask

    task automatic handshake();
        rdy1 = 1'b1;
        @(posedge clk);
        #1;
        rdy1 = 1'b0;
    endtask

    typedef struct {
        logic [30:0] seed;
        logic [30:0] first;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        bit ok;
        int l1, l4, l31;
        logic [30:0] dd1, dd4, dd31;
        int bad;
        int ecnt;
        logic [30:0] r;
        logic [30:0] exp_seq[3];

        vecs[0] = '{31'd478163327, 31'd1417889173};
        vecs[1] = '{31'd1, 31'd16};
        vecs[2] = '{31'd0, 31'd1};
        vecs[3] = '{31'd16, 31'd273};
        vecs[4] = '{31'd273, 31'd4096};

        #12;
        check("rst_valid", 32'(v1), 0);
        check("rst_data", 32'(d1), 0);
        check("rst_busy", 32'(b1), 0);
        check("rst_cnt", c1, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid", 32'(v1), 0);

        for (int i = 0; i < 5; i++) begin
            load(vecs[i].seed);
            l1 = 0; l4 = 0; l31 = 0;
            dd1 = '0; dd4 = '0; dd31 = '0;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk);
                #1;
                if (v1 && l1 == 0) begin l1 = c; dd1 = d1; end
                if (v4 && l4 == 0) begin l4 = c; dd4 = d4; end
                if (v31 && l31 == 0) begin l31 = c; dd31 = d31; end
            end
            check($sformatf("lat1_%0d", i), l1, 31);
            check($sformatf("lat4_%0d", i), l4, 8);
            check($sformatf("lat31_%0d", i), l31, 1);
            check($sformatf("data1_%0d", i), 32'(dd1), 32'(vecs[i].first));
            check($sformatf("data4_%0d", i), 32'(dd4), 32'(vecs[i].first));
            check($sformatf("data31_%0d", i), 32'(dd31), 32'(vecs[i].first));
        end

        exp_seq[0] = 31'd16;
        exp_seq[1] = 31'd273;
        exp_seq[2] = 31'd4096;
        rdy1 = 1'b1;
        load(31'd1);
        for (int k = 0; k < 3; k++) begin
            wait_valid(40, cyc, ok);
            check($sformatf("burst_gap_%0d", k), cyc, (k == 0) ? 31 : 32);
            check($sformatf("burst_data_%0d", k), 32'(d1), 32'(exp_seq[k]));
        end
        @(posedge clk);
        #1;
        rdy1 = 1'b0;
        check("burst_cnt", c1, cnt_exp(3));

        load(31'd0);
        wait_valid(40, cyc, ok);
        check("zero_first", 32'(d1), 1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (!v1 || d1 != 31'd1) bad++;
        end
        check("hold_stable", bad, 0);
        handshake();
        check("hs_cnt", c1, cnt_exp(1));
        wait_valid(40, cyc, ok);
        check("zero_second", 32'(d1), 16);

        load(31'd478163327);
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", 32'(b1), 1);
        load(31'd1);
        wait_valid(40, cyc, ok);
        check("abort_lat", cyc, 31);
        check("abort_data", 32'(d1), 16);
        check("abort_cnt", c1, 0);
        @(negedge clk);
        rdy1 = 1'b1;
        seed_load = 1'b1;
        seed = 31'd1;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        rdy1 = 1'b0;
        check("collide_valid", 32'(v1), 0);
        check("collide_cnt", c1, 0);
        wait_valid(40, cyc, ok);
        check("collide_lat", cyc, 31);
        check("collide_data", 32'(d1), 16);
        handshake();
        check("collide_cnt1", c1, cnt_exp(1));

        rdy1 = 1'b1;
        load(31'd5);
        for (int k = 0; k < 10; k++) wait_valid(40, cyc, ok);
        @(posedge clk);
        #1;
        rdy1 = 1'b0;
        check("ten_cnt", c1, cnt_exp(10));

        for (int t = 0; t < 6; t++) begin
            r = 31'($urandom);
            load(r);
            ecnt = 0;
            for (int k = 0; k < 4; k++) begin
                r = next_elem(r);
                wait_valid(40, cyc, ok);
                check($sformatf("rnd_lat_%0d_%0d", t, k), cyc, 31);
                check($sformatf("rnd_data_%0d_%0d", t, k), 32'(d1), 32'(r));
                bad = 0;
                for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
                    @(posedge clk);
                    #1;
                    if (!v1 || d1 != r) bad++;
                end
                check($sformatf("rnd_hold_%0d_%0d", t, k), bad, 0);
                handshake();
                ecnt++;
                check($sformatf("rnd_cnt_%0d_%0d", t, k), c1, cnt_exp(ecnt));
            end
        end

        load(31'd478163327);
        repeat (7) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rstc_valid", 32'(v1), 0);
        check("rstc_data", 32'(d1), 0);
        check("rstc_busy", 32'(b1), 0);
        check("rstc_cnt", c1, 0);
        @(negedge clk);
        rst = 1'b0;
        load(31'd1);
        wait_valid(40, cyc, ok);
        check("pre_rsto_data", 32'(d1), 16);
        #2;
        rst = 1'b1;
        #1;
        check("rsto_valid", 32'(v1), 0);
        check("rsto_data", 32'(d1), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
